// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit (req/gnt/rvalid data bus) and MEM/WB pipeline register.
// Define MEM_MISALIGN_CHK_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_stage_lsu #(
   parameter logic [6:0] LOAD_OP  = 7'b0000011,
   parameter logic [6:0] STORE_OP = 7'b0100011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_useful,
   input  logic [31:0] MEM_pc,
   input  logic [31:0] MEM_from_alu,
   input  logic [4:0]  MEM_wR,
   input  logic [31:0] MEM_data2,
   input  logic [6:0]  MEM_opcode,
   input  logic [2:0]  MEM_funct3,
   input  logic        MEM_regWEn,
   input  logic        MEM_memRW,
   input  logic [1:0]  MEM_wbSel,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_gnt,
   input  logic        dbus_rvalid,
   input  logic [31:0] dbus_rdata,
   output logic        mem_stall,
   output logic        WB_useful,
   output logic [4:0]  WB_wR,
   output logic        WB_regWEn,
   output logic [31:0] WB_wdata,
   output logic        WB_misalign
);
   localparam logic [1:0] FROM_ALU = 2'd0, FROM_MEM = 2'd1, FROM_PC = 2'd2;
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
   logic [1:0]  state_q, state_d, a;
   logic        is_ld, is_st, acc, mis, bus, complete;
   logic [3:0]  be;
   logic [15:0] rsh;
   logic [31:0] ld_val, wb_val;
   logic        wb_useful_q, wb_regwen_q, wb_mis_q;
   logic [4:0]  wb_wr_q;
   logic [31:0] wb_wdata_q;
   assign a     = MEM_from_alu[1:0];
   assign is_ld = MEM_useful & (MEM_opcode == LOAD_OP);
   assign is_st = MEM_useful & (MEM_opcode == STORE_OP) & MEM_memRW;
   assign acc   = is_ld | is_st;
`ifdef MEM_MISALIGN_CHK_EN
   assign mis = acc & (MEM_funct3[1] ? (a != 2'b00) : (MEM_funct3[0] & a[0]));
`else
   assign mis = 1'b0;
`endif
   assign bus      = acc & ~mis;
   // Loads finish only on rvalid in RESP; stores finish on the grant cycle.
   assign complete = (state_q == RESP) ? dbus_rvalid : (is_st & dbus_gnt);
   assign mem_stall = bus & ~complete;
   assign state_d = (state_q == RESP) ? (dbus_rvalid ? IDLE : RESP) :
                    !bus ? IDLE : !dbus_gnt ? REQ : is_ld ? RESP : IDLE;
   assign be = MEM_funct3[1] ? 4'b1111 : MEM_funct3[0] ? (4'b0011 << a) : (4'b0001 << a);
   assign dbus_req   = bus & (state_q != RESP);
   assign dbus_we    = bus & is_st;
   assign dbus_addr  = bus ? {MEM_from_alu[31:2], 2'b00} : 32'd0;
   assign dbus_be    = bus ? be : 4'b0000;
   assign dbus_wdata = !bus ? 32'd0 : MEM_funct3[1] ? MEM_data2 :
                       MEM_funct3[0] ? {2{MEM_data2[15:0]}} : {4{MEM_data2[7:0]}};
   assign rsh    = 16'(dbus_rdata >> {a, 3'b000});
   assign ld_val = MEM_funct3[1] ? dbus_rdata :
                   MEM_funct3[0] ? {{16{~MEM_funct3[2] & rsh[15]}}, rsh[15:0]} :
                                   {{24{~MEM_funct3[2] & rsh[7]}}, rsh[7:0]};
   assign wb_val = (MEM_wbSel == FROM_ALU) ? MEM_from_alu :
                   (MEM_wbSel == FROM_MEM) ? ld_val :
                   (MEM_wbSel == FROM_PC)  ? MEM_pc + 32'd4 : MEM_from_alu;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wb_useful_q <= 1'b0;
         wb_wr_q     <= 5'd0;
         wb_regwen_q <= 1'b0;
         wb_wdata_q  <= 32'd0;
         wb_mis_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (mem_stall) begin
            wb_useful_q <= 1'b0;
            wb_regwen_q <= 1'b0;
            wb_mis_q    <= 1'b0;
         end else begin
            wb_useful_q <= MEM_useful;
            wb_wr_q     <= MEM_wR;
            wb_regwen_q <= MEM_regWEn & MEM_useful & ~mis;
            wb_wdata_q  <= mis ? MEM_from_alu : wb_val;
            wb_mis_q    <= mis;
         end
      end
   end
   assign WB_useful   = wb_useful_q;
   assign WB_wR       = wb_wr_q;
   assign WB_regWEn   = wb_regwen_q;
   assign WB_wdata    = wb_wdata_q;
   assign WB_misalign = wb_mis_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed bench for mem_stage_lsu with a write-back scoreboard.
module tb_mem_stage_lsu;
   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, JAL = 7'b1101111, ALU = 7'b0110011;
   localparam logic [1:0] F_ALU = 2'd0, F_MEM = 2'd1, F_PC = 2'd2;
   typedef struct packed {logic [4:0] wr; logic wen; logic [31:0] wd; logic mis;} wb_t;
   logic clk = 1'b0, rst;
   logic MEM_useful, MEM_regWEn, MEM_memRW;
   logic [31:0] MEM_pc, MEM_from_alu, MEM_data2;
   logic [4:0] MEM_wR;
   logic [6:0] MEM_opcode;
   logic [2:0] MEM_funct3;
   logic [1:0] MEM_wbSel;
   logic dbus_req, dbus_we, dbus_gnt, dbus_rvalid, mem_stall;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0] dbus_be;
   logic WB_useful, WB_regWEn, WB_misalign;
   logic [4:0] WB_wR;
   logic [31:0] WB_wdata;
   int checks = 0, errors = 0;
   wb_t sb[$];
   logic [4:0] last_wr;
   logic [31:0] last_wd;
   always #5 clk = ~clk;
   mem_stage_lsu dut (
      .clk(clk), .rst(rst), .MEM_useful(MEM_useful), .MEM_pc(MEM_pc), .MEM_from_alu(MEM_from_alu),
      .MEM_wR(MEM_wR), .MEM_data2(MEM_data2), .MEM_opcode(MEM_opcode), .MEM_funct3(MEM_funct3),
      .MEM_regWEn(MEM_regWEn), .MEM_memRW(MEM_memRW), .MEM_wbSel(MEM_wbSel),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
      .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
      .mem_stall(mem_stall), .WB_useful(WB_useful), .WB_wR(WB_wR), .WB_regWEn(WB_regWEn),
      .WB_wdata(WB_wdata), .WB_misalign(WB_misalign)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic clr();
      MEM_useful = 0; MEM_pc = 0; MEM_from_alu = 0; MEM_wR = 0; MEM_data2 = 0; MEM_opcode = 0;
      MEM_funct3 = 0; MEM_regWEn = 0; MEM_memRW = 0; MEM_wbSel = 0;
      dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
   endtask
   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                            input logic [31:0] d2, input logic [4:0] wr, input logic wen,
                            input logic [1:0] sel, input logic [31:0] pc);
      MEM_useful = 1; MEM_opcode = op; MEM_funct3 = f3; MEM_from_alu = alu; MEM_data2 = d2;
      MEM_wR = wr; MEM_regWEn = wen; MEM_wbSel = sel; MEM_pc = pc; MEM_memRW = (op == ST);
   endtask
   // Drives gnt after gd cycles and rvalid rd cycles later (plus ignored early rvalids), then scores WB.
   task automatic run(input string tag, input int gd, input int rd, input logic [31:0] rdat,
                      input bit busx, input wb_t exp);
      int c = 0, stalls = 0, reqs = 0;
      bit done = 0, ld;
      logic [31:0] a0;
      wb_t e;
      ld = (MEM_opcode == LD);
      sb.push_back(exp);
      while (!done && c < 20) begin
         dbus_gnt = (c == gd);
         dbus_rvalid = ld && ((c == gd + rd) || (gd > 0 && (c == 0 || c == gd - 1)));
         dbus_rdata = (c == gd + rd) ? rdat : 32'hBAD0BAD0;
         #1;
         if (c == 0) a0 = dbus_addr;
         if (dbus_req) begin
            reqs++;
            chk({tag, " addr_stable"}, dbus_addr, a0);
         end
         if (c > 0) begin
            chk({tag, " bubble_useful"}, WB_useful, 0);
            chk({tag, " bubble_wen"}, WB_regWEn, 0);
            chk({tag, " bubble_wr"}, WB_wR, last_wr);
            chk({tag, " bubble_wd"}, WB_wdata, last_wd);
         end
         if (mem_stall) stalls++; else done = 1;
         if (!done) begin
            @(negedge clk);
            c++;
         end
      end
      chk({tag, " completed"}, done, 1);
      chk({tag, " stalls"}, stalls, busx ? (ld ? gd + rd : gd) : 0);
      chk({tag, " reqs"}, reqs, busx ? gd + 1 : 0);
      @(negedge clk);
      clr();
      #1;
      chk({tag, " sb_nonempty"}, sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, " wb_useful"}, WB_useful, 1);
         chk({tag, " wb_wr"}, WB_wR, e.wr);
         chk({tag, " wb_wen"}, WB_regWEn, e.wen);
         chk({tag, " wb_wdata"}, WB_wdata, e.wd);
         chk({tag, " wb_mis"}, WB_misalign, e.mis);
         last_wr = e.wr;
         last_wd = e.wd;
      end
   endtask
   initial begin
      rst = 1;
      clr();
      repeat (2) @(negedge clk);
      #1;
      chk("rst wb_useful", WB_useful, 0);
      chk("rst wb_wr", WB_wR, 0);
      chk("rst wb_wen", WB_regWEn, 0);
      chk("rst wb_wdata", WB_wdata, 0);
      chk("rst wb_mis", WB_misalign, 0);
      chk("rst req", dbus_req, 0);
      chk("rst stall", mem_stall, 0);
      rst = 0;
      last_wr = 0;
      last_wd = 0;
      set_instr(ST, 3'b010, 32'h40, 32'h11223344, 5'd5, 0, F_ALU, 32'h1000);
      run("sw_fill", 0, 0, 0, 1, wb_t'{5'd5, 1'b0, 32'h40, 1'b0});
      set_instr(LD, 3'b010, 32'h100, 0, 5'd5, 1, F_MEM, 32'h1004);
      #1;
      chk("lw addr", dbus_addr, 32'h100);
      chk("lw we", dbus_we, 0);
      run("lw", 0, 1, 32'hDEADBEEF, 1, wb_t'{5'd5, 1'b1, 32'hDEADBEEF, 1'b0});
      set_instr(ST, 3'b000, 32'h203, 32'h000000A5, 5'd0, 0, F_ALU, 32'h1008);
      #1;
      chk("sb be", dbus_be, 4'b1000);
      chk("sb wdata", dbus_wdata, 32'hA5A5A5A5);
      chk("sb addr", dbus_addr, 32'h200);
      chk("sb we", dbus_we, 1);
      run("sb", 0, 0, 0, 1, wb_t'{5'd0, 1'b0, 32'h203, 1'b0});
      set_instr(ST, 3'b001, 32'h2, 32'h1234BEEF, 5'd0, 0, F_ALU, 32'h100C);
      #1;
      chk("sh be", dbus_be, 4'b1100);
      chk("sh wdata", dbus_wdata, 32'hBEEFBEEF);
      run("sh", 0, 0, 0, 1, wb_t'{5'd0, 1'b0, 32'h2, 1'b0});
      set_instr(LD, 3'b000, 32'h101, 0, 5'd7, 1, F_MEM, 32'h1010);
      run("lb", 0, 1, 32'h00008000, 1, wb_t'{5'd7, 1'b1, 32'hFFFFFF80, 1'b0});
      set_instr(LD, 3'b100, 32'h101, 0, 5'd8, 1, F_MEM, 32'h1014);
      run("lbu", 0, 1, 32'h00008000, 1, wb_t'{5'd8, 1'b1, 32'h00000080, 1'b0});
      set_instr(LD, 3'b001, 32'h102, 0, 5'd9, 1, F_MEM, 32'h1018);
      run("lh", 0, 1, 32'h80010000, 1, wb_t'{5'd9, 1'b1, 32'hFFFF8001, 1'b0});
      set_instr(LD, 3'b101, 32'h102, 0, 5'd10, 1, F_MEM, 32'h101C);
      run("lhu", 0, 1, 32'h80010000, 1, wb_t'{5'd10, 1'b1, 32'h00008001, 1'b0});
      set_instr(LD, 3'b010, 32'h180, 0, 5'd11, 1, F_MEM, 32'h1020);
      run("lw_slow", 3, 2, 32'hCAFEF00D, 1, wb_t'{5'd11, 1'b1, 32'hCAFEF00D, 1'b0});
      set_instr(ST, 3'b010, 32'h84, 32'h55AA55AA, 5'd0, 0, F_ALU, 32'h1024);
      run("sw_slow", 2, 0, 0, 1, wb_t'{5'd0, 1'b0, 32'h84, 1'b0});
      set_instr(LD, 3'b010, 32'h300, 0, 5'd12, 1, F_MEM, 32'h1028);
      dbus_gnt = 1;
      #1;
      chk("rstmid req", dbus_req, 1);
      @(negedge clk);
      dbus_gnt = 0;
      rst = 1;
      #1;
      chk("rstmid resp_req", dbus_req, 0);
      chk("rstmid resp_stall", mem_stall, 1);
      @(negedge clk);
      rst = 0;
      dbus_rvalid = 1;
      dbus_rdata = 32'h12345678;
      #1;
      chk("rstmid wb_useful", WB_useful, 0);
      chk("rstmid wb_wr", WB_wR, 0);
      chk("rstmid wb_wen", WB_regWEn, 0);
      chk("rstmid wb_wdata", WB_wdata, 0);
      chk("rstmid wb_mis", WB_misalign, 0);
      chk("rstmid idle_req", dbus_req, 1);
      chk("rstmid idle_stall", mem_stall, 1);
      @(negedge clk);
      clr();
      #1;
      chk("rstmid discarded", WB_useful, 0);
      chk("rstmid req_drop", dbus_req, 0);
      last_wr = 0;
      last_wd = 0;
      @(negedge clk);
      set_instr(JAL, 3'b000, 32'h0, 0, 5'd1, 1, F_PC, 32'hFFFFFFFC);
      run("jal", 0, 0, 0, 0, wb_t'{5'd1, 1'b1, 32'h00000000, 1'b0});
`ifdef MEM_MISALIGN_CHK_EN
      set_instr(LD, 3'b010, 32'h102, 0, 5'd3, 1, F_MEM, 32'h1030);
      #1;
      chk("mis req", dbus_req, 0);
      run("mis_lw", 0, 1, 32'hBAD0BAD0, 0, wb_t'{5'd3, 1'b0, 32'h102, 1'b1});
`else
      set_instr(ST, 3'b001, 32'h203, 32'h00001234, 5'd0, 0, F_ALU, 32'h1030);
      #1;
      chk("sh3 be", dbus_be, 4'b1000);
      chk("sh3 addr", dbus_addr, 32'h200);
      run("sh3", 0, 0, 0, 1, wb_t'{5'd0, 1'b0, 32'h203, 1'b0});
`endif
      set_instr(ALU, 3'b000, 32'h77, 0, 5'd4, 1, F_ALU, 32'h1034);
      run("alu", 0, 0, 0, 0, wb_t'{5'd4, 1'b1, 32'h77, 1'b0});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit and MEM/WB pipeline register. It consumes the MEM_* bundle produced by the EX/MEM register and runs a req/gnt/rvalid handshake on the data bus for loads and stores. It stalls the upstream pipeline while an access is in flight and registers the write-back bundle (WB_*) for the register file.

Parameters:
- LOAD_OP, 7'b0000011, opcode that identifies a load
- STORE_OP, 7'b0100011, opcode that identifies a store

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- MEM_useful  input  1  valid instruction in MEM
- MEM_pc  input  32  instruction PC
- MEM_from_alu  input  32  ALU result; also the effective address
- MEM_wR  input  5  destination register
- MEM_data2  input  32  store data (rs2)
- MEM_opcode  input  7  instruction opcode
- MEM_funct3  input  3  access size and signedness
- MEM_regWEn  input  1  register write enable
- MEM_memRW  input  1  1 = store
- MEM_wbSel  input  2  `FROM_ALU / `FROM_MEM / `FROM_PC
- dbus_req  output  1  bus request
- dbus_we  output  1  bus write
- dbus_addr  output  32  word address; bits [1:0] always 0
- dbus_be  output  4  byte enables
- dbus_wdata  output  32  write data, lane-replicated
- dbus_gnt  input  1  request accepted
- dbus_rvalid  input  1  read data valid
- dbus_rdata  input  32  read data
- mem_stall  output  1  hold IF..MEM stages
- WB_useful  output  1  valid instruction in WB
- WB_wR  output  5  destination register
- WB_regWEn  output  1  register write enable
- WB_wdata  output  32  write-back value
- WB_misalign  output  1  misaligned access flag (optional feature)

Behaviour:
- Decoded access signals:
  - is_ld = MEM_useful & opcode==LOAD_OP
  - is_st = MEM_useful & opcode==STORE_OP & MEM_memRW
  - acc = is_ld | is_st
- FSM states: IDLE, REQ, RESP. Reset value is IDLE.
- IDLE behaviour:
  - dbus_req = acc, combinational.
  - If acc & gnt: a store completes this cycle; a load goes to RESP.
  - If acc & !gnt: go to REQ.
- REQ behaviour:
  - dbus_req=1. addr, be, we and wdata stay stable until gnt.
  - On gnt: a store completes and returns to IDLE; a load goes to RESP.
- RESP behaviour:
  - dbus_req=0. Wait for rvalid; the load completes on the rvalid cycle, then return to IDLE.
  - A same-cycle new access in IDLE is not possible, because upstream changes only after completion.
- rvalid is ignored in IDLE and REQ.
- mem_stall = acc & !complete_this_cycle, combinational.
  - A store granted in IDLE gives 0 stall cycles.
  - A load with gnt in IDLE and rvalid on the next cycle gives 1 stall cycle.
- Byte enables, with a = addr[1:0]:
  - SB: 4'b0001<<a
  - SH: 4'b0011<<a
  - SW: 4'b1111
- Write data lanes:
  - SB: data2[7:0] x4
  - SH: data2[15:0] x2
  - SW: data2 unchanged
- Load extraction:
  - Select the byte or half by a from rdata.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW is unchanged.
- WB register, clocked on posedge clk:
  - rst: every WB_* output resets to 0.
  - else if mem_stall: insert a bubble (WB_useful=0, WB_regWEn=0); the other WB fields hold.
  - else capture:
    - WB_useful = MEM_useful
    - WB_wR = MEM_wR
    - WB_regWEn = MEM_regWEn & MEM_useful
    - WB_wdata = from_alu for `FROM_ALU, the extracted load for `FROM_MEM, pc+4 for `FROM_PC (mod 2^32)
- Reset mid-transaction: FSM returns to IDLE, dbus_req drops next cycle, and any pending rvalid is discarded.
- dbus outputs reset to 0 whenever acc=0.

Optional Feature:
- MEM_MISALIGN_CHK_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, counts as misaligned.
  - No bus request and no stall.
  - WB captures WB_useful=1, WB_regWEn=0, WB_misalign=1, WB_wdata=faulting address.
  - WB_misalign is 1 for one cycle.
- MEM_MISALIGN_CHK_EN undefined:
  - WB_misalign is tied 0.
  - Accesses proceed; be is truncated to 4 bits, so e.g. SH at a=3 gives 4'b1000.

Test Plan:
1. Fill WB with SW x5, then issue LW addr 0x100, gnt in IDLE, rvalid next cycle with 0xDEADBEEF -> mem_stall high 1 cycle; WB_wdata=0xDEADBEEF, WB_regWEn=1, WB_wR=5; the stall-cycle WB is a bubble (WB_useful=0, WB_regWEn=0, other fields hold).
2. SB data2=0x000000A5 at addr 0x203, gnt immediate -> dbus_be=4'b1000, dbus_wdata=0xA5A5A5A5, dbus_addr=0x200, no stall.
3. LB addr 0x101, rdata 0x00008000 -> WB_wdata=0xFFFFFF80; same access as LBU -> 0x00000080.
4. LW with gnt delayed 3 cycles, then rvalid after 2 more cycles -> req held 4 cycles with a stable address, 5 stall cycles, rvalid before gnt ignored.
5. rst asserted while in RESP, rvalid arrives the next cycle -> FSM in IDLE, all WB_* outputs 0, data discarded.
6. JAL-type (wbSel=`FROM_PC, pc=0xFFFFFFFC) -> WB_wdata=0x00000000; with MEM_MISALIGN_CHK_EN, LW at 0x102 -> no dbus_req, WB_misalign=1, WB_wdata=0x102.
